// File: rtl/dram_op_scheduler_if.sv
// rtl/dram_op_scheduler_if.sv - host operation request/response bundle for dram_op_scheduler
interface dram_op_scheduler_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 256
);
  logic              op_valid;
  logic              op_ready;
  logic [1:0]        op_type;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic [15:0]       op_r1;
  logic [15:0]       op_r2;
  logic [3:0]        op_t1;
  logic [3:0]        op_t2;
  logic              resp_valid;
  logic              resp_ready;
  logic [1:0]        resp_type;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  modport master (
    output op_valid, op_type, op_addr, op_wdata, op_r1, op_r2, op_t1, op_t2, resp_ready,
    input  op_ready, resp_valid, resp_type, resp_data, resp_err
  );

  modport slave (
    input  op_valid, op_type, op_addr, op_wdata, op_r1, op_r2, op_t1, op_t2, resp_ready,
    output op_ready, resp_valid, resp_type, resp_data, resp_err
  );
endinterface

// File: rtl/dram_op_scheduler.sv
// rtl/dram_op_scheduler.sv - one-at-a-time scheduler of native write/read and ComputeDRAM ops
module dram_op_scheduler #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 256,
  parameter int COMPUTE_GAP = 16,
  parameter int TIMEOUT     = 1024
) (
  input  logic                user_clk,
  input  logic                user_rst,
  input  logic                init_done,
  dram_op_scheduler_if.slave  op_if,
  output logic                cmd_valid,
  output logic                cmd_we,
  output logic [ADDR_W-1:0]   cmd_addr,
  input  logic                cmd_ready,
  output logic                wdata_valid,
  output logic [DATA_W/8-1:0] wdata_we,
  output logic [DATA_W-1:0]   wdata_data,
  input  logic                wdata_ready,
  input  logic                rdata_valid,
  input  logic [DATA_W-1:0]   rdata_data,
  output logic                rdata_ready,
  output logic [15:0]         cd_r1,
  output logic [15:0]         cd_r2,
  output logic [3:0]          cd_t1,
  output logic [3:0]          cd_t2,
  output logic                cd_vld,
  input  logic                cd_rdy,
  output logic                busy,
  output logic                err_sticky
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = ($clog2(TIMEOUT) > 11) ? $clog2(TIMEOUT) : 11;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(COMPUTE_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD_CMD, S_RD_DATA, S_CD_REQ, S_CD_GAP, S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cmd_done_q, cmd_done_d, data_done_q, data_done_d;
  logic              cmd_valid_q, cmd_valid_d, cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic              wdata_valid_q, wdata_valid_d;
  logic [BE_W-1:0]   wdata_we_q, wdata_we_d;
  logic [DATA_W-1:0] wdata_data_q, wdata_data_d;
  logic              rdata_ready_q, rdata_ready_d;
  logic [15:0]       cd_r1_q, cd_r1_d, cd_r2_q, cd_r2_d;
  logic [3:0]        cd_t1_q, cd_t1_d, cd_t2_q, cd_t2_d;
  logic              cd_vld_q, cd_vld_d;
  logic              resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [1:0]        resp_type_q, resp_type_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              err_sticky_q, err_sticky_d;

  logic op_ready, accept, tmo, fail, cmd_hs, data_hs, cdone, ddone;

  assign op_ready = (state_q == S_IDLE) && init_done && !resp_valid_q;
  assign accept   = op_if.op_valid && op_ready;
  assign tmo      = (cnt_q == TMO_LAST);
  assign cmd_hs   = cmd_valid_q && cmd_ready;
  assign data_hs  = wdata_valid_q && wdata_ready;
  assign cdone    = cmd_done_q || cmd_hs;
  assign ddone    = data_done_q || data_hs;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_done_d    = cmd_done_q;
    data_done_d   = data_done_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_we_d      = cmd_we_q;
    cmd_addr_d    = cmd_addr_q;
    wdata_valid_d = wdata_valid_q;
    wdata_we_d    = wdata_we_q;
    wdata_data_d  = wdata_data_q;
    rdata_ready_d = rdata_ready_q;
    cd_r1_d       = cd_r1_q;
    cd_r2_d       = cd_r2_q;
    cd_t1_d       = cd_t1_q;
    cd_t2_d       = cd_t2_q;
    cd_vld_d      = cd_vld_q;
    resp_valid_d  = resp_valid_q;
    resp_err_d    = resp_err_q;
    resp_type_d   = resp_type_q;
    resp_data_d   = resp_data_q;
    err_sticky_d  = err_sticky_q;
    fail          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d       = '0;
          resp_type_d = op_if.op_type;
          resp_data_d = '0;
          resp_err_d  = 1'b0;
          case (op_if.op_type)
            2'd0: begin
              state_d       = S_WR;
              cmd_done_d    = 1'b0;
              data_done_d   = 1'b0;
              cmd_valid_d   = 1'b1;
              cmd_we_d      = 1'b1;
              cmd_addr_d    = op_if.op_addr;
              wdata_valid_d = 1'b1;
              wdata_we_d    = '1;
              wdata_data_d  = op_if.op_wdata;
            end
            2'd1: begin
              state_d     = S_RD_CMD;
              cmd_valid_d = 1'b1;
              cmd_we_d    = 1'b0;
              cmd_addr_d  = op_if.op_addr;
            end
            2'd2: begin
              state_d  = S_CD_REQ;
              cd_vld_d = 1'b1;
              cd_r1_d  = op_if.op_r1;
              cd_r2_d  = op_if.op_r2;
              cd_t1_d  = op_if.op_t1;
              cd_t2_d  = op_if.op_t2;
            end
            default: begin
              state_d      = S_RESP;
              resp_valid_d = 1'b1;
              resp_err_d   = 1'b1;
              err_sticky_d = 1'b1;
            end
          endcase
        end
      end
      S_WR: begin
        // Command and data channels complete independently; each valid drops after its own handshake.
        cmd_done_d  = cdone;
        data_done_d = ddone;
        if (cmd_hs) begin
          cmd_valid_d = 1'b0;
          cmd_we_d    = 1'b0;
        end
        if (data_hs) begin
          wdata_valid_d = 1'b0;
          wdata_we_d    = '0;
        end
        if (cdone && ddone) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
        end else if (tmo) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RD_CMD: begin
        if (cmd_hs) begin
          state_d       = S_RD_DATA;
          cmd_valid_d   = 1'b0;
          rdata_ready_d = 1'b1;
          cnt_d         = '0;
        end else if (tmo) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RD_DATA: begin
        if (rdata_ready_q && rdata_valid) begin
          state_d       = S_RESP;
          rdata_ready_d = 1'b0;
          resp_data_d   = rdata_data;
          resp_valid_d  = 1'b1;
        end else if (tmo) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CD_REQ: begin
        if (cd_vld_q && cd_rdy) begin
          state_d  = S_CD_GAP;
          cd_vld_d = 1'b0;
          cd_r1_d  = '0;
          cd_r2_d  = '0;
          cd_t1_d  = '0;
          cd_t2_d  = '0;
          cnt_d    = '0;
        end else if (tmo) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CD_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (op_if.resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A stalled handshake abandons the op and reports an error response with no data.
    if (fail) begin
      state_d       = S_RESP;
      cmd_valid_d   = 1'b0;
      cmd_we_d      = 1'b0;
      wdata_valid_d = 1'b0;
      wdata_we_d    = '0;
      rdata_ready_d = 1'b0;
      cd_vld_d      = 1'b0;
      cd_r1_d       = '0;
      cd_r2_d       = '0;
      cd_t1_d       = '0;
      cd_t2_d       = '0;
      resp_valid_d  = 1'b1;
      resp_err_d    = 1'b1;
      resp_data_d   = '0;
      err_sticky_d  = 1'b1;
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      cmd_done_q    <= 1'b0;
      data_done_q   <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_we_q      <= 1'b0;
      cmd_addr_q    <= '0;
      wdata_valid_q <= 1'b0;
      wdata_we_q    <= '0;
      wdata_data_q  <= '0;
      rdata_ready_q <= 1'b0;
      cd_r1_q       <= '0;
      cd_r2_q       <= '0;
      cd_t1_q       <= '0;
      cd_t2_q       <= '0;
      cd_vld_q      <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_type_q   <= '0;
      resp_data_q   <= '0;
      err_sticky_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_done_q    <= cmd_done_d;
      data_done_q   <= data_done_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_we_q      <= cmd_we_d;
      cmd_addr_q    <= cmd_addr_d;
      wdata_valid_q <= wdata_valid_d;
      wdata_we_q    <= wdata_we_d;
      wdata_data_q  <= wdata_data_d;
      rdata_ready_q <= rdata_ready_d;
      cd_r1_q       <= cd_r1_d;
      cd_r2_q       <= cd_r2_d;
      cd_t1_q       <= cd_t1_d;
      cd_t2_q       <= cd_t2_d;
      cd_vld_q      <= cd_vld_d;
      resp_valid_q  <= resp_valid_d;
      resp_err_q    <= resp_err_d;
      resp_type_q   <= resp_type_d;
      resp_data_q   <= resp_data_d;
      err_sticky_q  <= err_sticky_d;
    end
  end

  assign op_if.op_ready   = op_ready;
  assign op_if.resp_valid = resp_valid_q;
  assign op_if.resp_type  = resp_type_q;
  assign op_if.resp_data  = resp_data_q;
  assign op_if.resp_err   = resp_err_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_we      = cmd_we_q;
  assign cmd_addr    = cmd_addr_q;
  assign wdata_valid = wdata_valid_q;
  assign wdata_we    = wdata_we_q;
  assign wdata_data  = wdata_data_q;
  assign rdata_ready = rdata_ready_q;
  assign cd_r1       = cd_r1_q;
  assign cd_r2       = cd_r2_q;
  assign cd_t1       = cd_t1_q;
  assign cd_t2       = cd_t2_q;
  assign cd_vld      = cd_vld_q;
  assign busy        = (state_q != S_IDLE);
  assign err_sticky  = err_sticky_q;
endmodule

// File: tb/tb_dram_op_scheduler.sv
// tb/tb_dram_op_scheduler.sv - directed self-checking bench for dram_op_scheduler
module tb_dram_op_scheduler;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 256;
  localparam int GAP    = 16;
  localparam int TMO    = 1024;

  logic              user_clk = 1'b0;
  logic              user_rst;
  logic              init_done;
  logic              cmd_valid, cmd_we, cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic              wdata_valid, wdata_ready;
  logic [31:0]       wdata_we;
  logic [DATA_W-1:0] wdata_data;
  logic              rdata_valid, rdata_ready;
  logic [DATA_W-1:0] rdata_data;
  logic [15:0]       cd_r1, cd_r2;
  logic [3:0]        cd_t1, cd_t2;
  logic              cd_vld, cd_rdy;
  logic              busy, err_sticky;

  int n_chk  = 0;
  int n_fail = 0;

  dram_op_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dram_op_scheduler #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .COMPUTE_GAP(GAP), .TIMEOUT(TMO)
  ) dut (
    .user_clk(user_clk), .user_rst(user_rst), .init_done(init_done), .op_if(bus.slave),
    .cmd_valid(cmd_valid), .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_ready(cmd_ready),
    .wdata_valid(wdata_valid), .wdata_we(wdata_we), .wdata_data(wdata_data), .wdata_ready(wdata_ready),
    .rdata_valid(rdata_valid), .rdata_data(rdata_data), .rdata_ready(rdata_ready),
    .cd_r1(cd_r1), .cd_r2(cd_r2), .cd_t1(cd_t1), .cd_t2(cd_t2), .cd_vld(cd_vld), .cd_rdy(cd_rdy),
    .busy(busy), .err_sticky(err_sticky)
  );

  always #5 user_clk = ~user_clk;

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] t, input logic [23:0] a, input logic [255:0] d);
    bus.op_valid = 1'b1;
    bus.op_type  = t;
    bus.op_addr  = a;
    bus.op_wdata = d;
    chk("op_ready_idle", bus.op_ready, 1);
    tick();
    bus.op_valid = 1'b0;
  endtask

  task automatic wait_resp(input string tag, input int budget, output int n);
    n = 0;
    while (!bus.resp_valid && n < budget) begin
      tick();
      n++;
    end
    if (!bus.resp_valid) chk({tag, "_no_resp"}, 0, 1);
  endtask

  task automatic consume();
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] wd;
    logic [255:0] aa;
    int cv, wv, rv, rr, bad, n, nat;

    user_rst = 1'b1; init_done = 1'b0;
    cmd_ready = 1'b0; wdata_ready = 1'b0; rdata_valid = 1'b0; rdata_data = '0; cd_rdy = 1'b0;
    bus.op_valid = 1'b0; bus.op_type = '0; bus.op_addr = '0; bus.op_wdata = '0;
    bus.op_r1 = '0; bus.op_r2 = '0; bus.op_t1 = '0; bus.op_t2 = '0; bus.resp_ready = 1'b0;
    tick(); tick();
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_wdata_we", wdata_we, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_ready", bus.op_ready, 0);
    user_rst = 1'b0; init_done = 1'b1;
    tick();

    // Write, both readies high
    wd = {{240{1'b1}}, 16'h0101};
    cmd_ready = 1'b1; wdata_ready = 1'b1;
    send(2'd0, 24'h000008, wd);
    chk("w1_cmd_valid", cmd_valid, 1);
    chk("w1_wdata_valid", wdata_valid, 1);
    chk("w1_cmd_we", cmd_we, 1);
    chk("w1_addr", cmd_addr, 24'h000008);
    chk("w1_we", wdata_we, 32'hffffffff);
    chk("w1_data", wdata_data, wd);
    chk("w1_busy", busy, 1);
    chk("w1_op_ready_busy", bus.op_ready, 0);
    tick();
    chk("w1_cmd_drop", cmd_valid, 0);
    chk("w1_wdata_drop", wdata_valid, 0);
    chk("w1_resp_valid", bus.resp_valid, 1);
    chk("w1_resp_type", bus.resp_type, 0);
    chk("w1_resp_err", bus.resp_err, 0);
    consume();
    chk("w1_resp_cleared", bus.resp_valid, 0);

    // Write, cmd_ready late by three cycles
    cmd_ready = 1'b0;
    send(2'd0, 24'h000010, 256'h1234);
    cv = 0; wv = 0; rv = 0;
    for (int i = 1; i <= 4; i++) begin
      cv += int'(cmd_valid); wv += int'(wdata_valid); rv += int'(bus.resp_valid);
      if (i == 4) cmd_ready = 1'b1;
      tick();
    end
    chk("w2_cmd_cycles", cv, 4);
    chk("w2_wdata_cycles", wv, 1);
    chk("w2_early_resp", rv, 0);
    chk("w2_cmd_drop", cmd_valid, 0);
    chk("w2_resp_valid", bus.resp_valid, 1);
    consume();
    chk("w2_single_resp", bus.resp_valid, 0);

    // Read with rdata five cycles after the command handshake
    aa = {32{8'hAA}};
    send(2'd1, 24'h0000f0, '0);
    chk("r_cmd_valid", cmd_valid, 1);
    chk("r_cmd_we", cmd_we, 0);
    chk("r_addr", cmd_addr, 24'h0000f0);
    chk("r_rready_cmd", rdata_ready, 0);
    tick();
    chk("r_cmd_drop", cmd_valid, 0);
    rr = 0; rv = 0;
    for (int i = 2; i <= 6; i++) begin
      rr += int'(rdata_ready); rv += int'(bus.resp_valid);
      if (i == 6) begin rdata_valid = 1'b1; rdata_data = aa; end
      tick();
    end
    rdata_valid = 1'b0; rdata_data = '0;
    chk("r_rready_cycles", rr, 5);
    chk("r_early_resp", rv, 0);
    chk("r_resp_valid", bus.resp_valid, 1);
    chk("r_resp_data", bus.resp_data, aa);
    chk("r_resp_type", bus.resp_type, 1);
    chk("r_resp_err", bus.resp_err, 0);
    chk("r_rready_after", rdata_ready, 0);
    consume();

    // Compute with cd_rdy after two cycles
    bus.op_r1 = 16'd4; bus.op_r2 = 16'd5; bus.op_t1 = 4'd2; bus.op_t2 = 4'd2;
    send(2'd2, '0, '0);
    bad = 0;
    for (int i = 1; i <= 3; i++) begin
      if (cd_vld !== 1'b1 || cd_r1 !== 16'd4 || cd_r2 !== 16'd5 || cd_t1 !== 4'd2 || cd_t2 !== 4'd2) bad++;
      if (i == 3) cd_rdy = 1'b1;
      tick();
    end
    cd_rdy = 1'b0;
    chk("cd_stable", bad, 0);
    chk("cd_vld_drop", cd_vld, 0);
    chk("cd_r1_clr", cd_r1, 0);
    chk("cd_t2_clr", cd_t2, 0);
    n = 0; nat = 0;
    while (!bus.resp_valid && n < 300) begin
      nat += int'(cmd_valid | wdata_valid | rdata_ready | cd_vld);
      tick();
      n++;
    end
    chk("cd_gap_cycles", n, GAP);
    chk("cd_gap_quiet", nat, 0);
    chk("cd_resp_type", bus.resp_type, 2);
    chk("cd_resp_data", bus.resp_data, 0);
    chk("cd_resp_err", bus.resp_err, 0);
    consume();

    // Read with cmd_ready stuck low
    chk("sticky_clean", err_sticky, 0);
    cmd_ready = 1'b0;
    send(2'd1, 24'h000123, '0);
    wait_resp("tmo", 2000, n);
    chk("tmo_cycles", n, TMO);
    chk("tmo_err", bus.resp_err, 1);
    chk("tmo_sticky", err_sticky, 1);
    chk("tmo_cmd_drop", cmd_valid, 0);
    chk("tmo_data", bus.resp_data, 0);
    chk("tmo_type", bus.resp_type, 1);
    consume();
    cmd_ready = 1'b1;
    send(2'd0, 24'h000020, 256'h5);
    tick();
    chk("post_tmo_resp", bus.resp_valid, 1);
    chk("post_tmo_err", bus.resp_err, 0);
    chk("post_tmo_sticky", err_sticky, 1);
    consume();

    // Reset during CD_GAP abandons the op
    cd_rdy = 1'b1;
    send(2'd2, '0, '0);
    tick(); tick();
    cd_rdy = 1'b0;
    chk("gap_busy", busy, 1);
    user_rst = 1'b1;
    tick();
    user_rst = 1'b0;
    chk("rst2_busy", busy, 0);
    chk("rst2_sticky", err_sticky, 0);
    chk("rst2_cd_vld", cd_vld, 0);
    chk("rst2_wdata_we", wdata_we, 0);
    chk("rst2_cmd_addr", cmd_addr, 0);
    rv = 0;
    for (int i = 0; i < 20; i++) begin
      rv += int'(bus.resp_valid);
      tick();
    end
    chk("rst2_no_resp", rv, 0);

    // Reserved type, then pending response and init_done low both block acceptance
    send(2'd3, '0, '0);
    chk("rsv_resp_valid", bus.resp_valid, 1);
    chk("rsv_err", bus.resp_err, 1);
    chk("rsv_type", bus.resp_type, 3);
    chk("rsv_sticky", err_sticky, 1);
    bus.op_valid = 1'b1; bus.op_type = 2'd0; bus.op_addr = 24'h000040;
    cv = 0; rr = 0;
    for (int i = 0; i < 3; i++) begin
      cv += int'(bus.op_ready); rr += int'(cmd_valid);
      tick();
    end
    chk("pend_op_ready", cv, 0);
    chk("pend_no_cmd", rr, 0);
    init_done = 1'b0;
    consume();
    chk("init_low_resp", bus.resp_valid, 0);
    cv = 0; rr = 0;
    for (int i = 0; i < 3; i++) begin
      cv += int'(bus.op_ready); rr += int'(cmd_valid | busy);
      tick();
    end
    chk("init_low_op_ready", cv, 0);
    chk("init_low_idle", rr, 0);
    init_done = 1'b1;
    #1;
    chk("init_high_op_ready", bus.op_ready, 1);
    tick();
    bus.op_valid = 1'b0;
    chk("init_high_accept", cmd_valid, 1);
    chk("init_high_addr", cmd_addr, 24'h000040);
    wait_resp("last", 20, n);
    chk("last_resp_err", bus.resp_err, 0);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dram_op_scheduler.md
Name: dram_op_scheduler

Overview:
- Sequences host operations onto the LiteDRAM core: native-port writes, native-port reads and ComputeDRAM row operations (R1/R2/T1/T2).
- Runs one operation at a time, so a ComputeDRAM op never overlaps native-port traffic.
- Returns one response per operation.
- Sits between the user/test logic and the litedram_core user port and ComputeDRAM inputs, in the user_clk domain.

Parameters:
- ADDR_W, 24, native-port command address width.
- DATA_W, 256, native-port data width; byte-enable width is DATA_W/8.
- COMPUTE_GAP, 16, idle user_clk cycles enforced after a ComputeDRAM handshake before the op completes; range 1..255.
- TIMEOUT, 1024, max cycles waiting on any single handshake before flagging an error.

Ports:
- user_clk  in  1  clock
- user_rst  in  1  reset; synchronous, active-high
- init_done  in  1  DRAM calibration complete; no op accepted while low
- op_valid  in  1  operation request valid
- op_ready  out  1  operation accepted when op_valid && op_ready
- op_type  in  2  0=write, 1=read, 2=compute, 3=reserved
- op_addr  in  ADDR_W  native address (write/read)
- op_wdata  in  DATA_W  write data
- op_r1, op_r2  in  16 each  ComputeDRAM rows
- op_t1, op_t2  in  4 each  ComputeDRAM timings
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumed
- resp_type  out  2  echoed op_type
- resp_data  out  DATA_W  read data (zero for write/compute)
- resp_err  out  1  op timed out or type was reserved
- cmd_valid, cmd_we  out  1 each  native command
- cmd_addr  out  ADDR_W  native command address
- cmd_ready  in  1  native command ready
- wdata_valid  out  1  native write data valid
- wdata_we  out  DATA_W/8  native write byte enables
- wdata_data  out  DATA_W  native write data
- wdata_ready  in  1  native write data ready
- rdata_valid  in  1  native read data valid
- rdata_data  in  DATA_W  native read data
- rdata_ready  out  1  native read data ready
- cd_r1, cd_r2  out  16 each  ComputeDRAM rows
- cd_t1, cd_t2  out  4 each  ComputeDRAM timings
- cd_vld  out  1  ComputeDRAM request valid
- cd_rdy  in  1  ComputeDRAM ready
- busy  out  1  state != IDLE
- err_sticky  out  1  set on any resp_err; cleared only by reset

Behaviour:
- Reset state: user_rst sampled at the user_clk edge forces state IDLE and every output to 0 (wdata_we included).
  - Reset mid-operation abandons the op immediately: no response, and all native/ComputeDRAM valids drop the next cycle.
- op_ready = (state==IDLE) && init_done && !resp_valid. The accept cycle registers every op_* field.
- States:
  - IDLE: on accept, go to WR (type 0), RD_CMD (type 1), CD_REQ (type 2) or RESP with resp_err=1 (type 3).
  - WR:
    - Assert cmd_valid=1, cmd_we=1, wdata_valid=1, wdata_we=all-ones.
    - Track cmd_done and data_done flags independently.
    - After a handshake, drop the matching valid on the next cycle; either handshake may come first or both may occur in the same cycle.
    - Go to RESP once both flags are set.
  - RD_CMD: cmd_valid=1, cmd_we=0. On cmd_ready go to RD_DATA.
  - RD_DATA: rdata_ready=1. On rdata_valid capture rdata_data into resp_data, then go to RESP.
  - CD_REQ: drive cd_* from the registered fields with cd_vld=1. On cd_vld && cd_rdy clear cd_vld next cycle and cd_r*/cd_t* to 0, then go to CD_GAP.
  - CD_GAP: count COMPUTE_GAP cycles, then go to RESP. No native valid is asserted in this state.
  - RESP:
    - resp_valid=1 with resp_type, resp_data and resp_err held stable.
    - On resp_ready clear resp_valid and go to IDLE.
    - The earliest next accept is the cycle after.
- Timeout:
  - An 11-bit-min counter runs in WR, RD_CMD, RD_DATA and CD_REQ and resets on each state entry.
  - When it reaches TIMEOUT-1: deassert all valids, set resp_err=1 and err_sticky=1, go to RESP; resp_data=0.
- init_done:
  - Falling mid-op does not abort the op.
  - Only new acceptance is blocked.
- Minimum latency, accept to resp_valid:
  - write: 2 cycles, given immediate readies.
  - read: 3 cycles plus rdata latency.
  - compute: 2 + COMPUTE_GAP cycles.
- No combinational path from any input to any output except op_ready (from resp_valid/state) — all others registered.

Test Plan:
- Write with both readies high at addr 0x000008 and data ...ffff_0101 → single cycle with cmd_valid=wdata_valid=1, addr 0x000008, wdata_we=0xffffffff; resp_type=0 and resp_err=0 two cycles after accept.
- Write, cmd_ready delayed 3 cycles, wdata_ready immediate → wdata_valid drops after 1 cycle, cmd_valid holds 4 cycles, one resp.
- Read at 0x0000f0, rdata_valid returns 0xAA..AA 5 cycles later → resp_data=0xAA..AA, resp_type=1; rdata_ready low outside RD_DATA.
- Compute R1=4, R2=5, T1=2, T2=2, cd_rdy high after 2 cycles → cd_* stable while cd_vld=1; resp exactly COMPUTE_GAP cycles after the handshake; no cmd_valid during gap.
- cmd_ready stuck low → resp_err=1 after TIMEOUT cycles, err_sticky=1; next op is still accepted.
- user_rst pulsed during CD_GAP, resp_ready held low with a pending resp, and init_done=0 → all outputs 0 after reset; no op accepted while resp_valid is pending or init_done is low.
